// File: rtl/intl_evt_pkg.sv
// Shared types and helpers for the interlock event logger.
// INTL_W is the width of the interlock state vector. An event entry holds
// {ts, state, bits}, with ts in the most significant bits. intl_evt_entry_t
// shows that layout for the default 32-bit timestamp. The top level declares
// the same field order with its own TS_W.
package intl_evt_pkg;

  localparam int INTL_W   = 16;
  localparam int TS_DEF_W = 32;

  typedef struct packed {
    logic [TS_DEF_W-1:0] ts;
    logic [INTL_W-1:0]   state;
    logic [INTL_W-1:0]   bits;
  } intl_evt_entry_t;

  // Width of one FIFO word for a given timestamp width.
  function automatic int entry_w(input int ts_w);
    return ts_w + 2 * INTL_W;
  endfunction

endpackage

// File: rtl/intl_evt_fifo.sv
// Synchronous show-ahead FIFO.
// The head word is always present on rd_data, read from the registered read
// pointer. Each pointer carries one extra MSB, which lets the FIFO tell full
// from empty.
// Handshake:
//   - push is accepted when the FIFO is not full, or when an accepted pop
//     occurs in the same cycle.
//   - pop is accepted only when the FIFO is not empty at the clock edge.
//   - flush has priority over both and discards any same-cycle push.
module intl_evt_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  // When full, a same-cycle pop frees the slot that this push overwrites.
  assign do_push = push & (~full | do_pop);

  // Pointer update; reset and flush both return the FIFO to empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write. Contents need no reset because the pointers gate validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/intl_event_logger.sv
// Timestamped interlock event recorder.
// It detects newly asserted interlock bits and queues each event with a
// timestamp and a state snapshot. It also latches the first fault seen since
// the last interlock reset.
// Optional build macro: INTL_EVT_FALL_LOG_EN. When it is defined, cleared
// bits also raise events. The first-fault latch always uses rising bits only.
module intl_event_logger
  import intl_evt_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [15:0]            i_intl_state,
  input  logic                   i_intl_rst,
  input  logic                   i_flush,
  input  logic                   i_rd_en,
  output logic                   o_evt_valid,
  output logic [TS_W-1:0]        o_evt_ts,
  output logic [15:0]            o_evt_state,
  output logic [15:0]            o_evt_bits,
  output logic [$clog2(DEPTH):0] o_evt_count,
  output logic                   o_overflow,
  output logic                   o_first_valid,
  output logic [15:0]            o_first_bits,
  output logic [TS_W-1:0]        o_first_ts,
  output logic [TS_W-1:0]        o_ts
);

  localparam int EW = entry_w(TS_W);

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [INTL_W-1:0] state;
    logic [INTL_W-1:0] bits;
  } entry_t;

  logic [TS_W-1:0]        ts;
  logic [INTL_W-1:0]      prev;
  logic [INTL_W-1:0]      rise;
  logic [INTL_W-1:0]      evt_bits;
  logic                   evt;
  logic                   push;
  logic                   drop;
  entry_t                 wr_entry;
  entry_t                 rd_entry;
  logic [EW-1:0]          rd_word;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic                   first_valid;
  logic [INTL_W-1:0]      first_bits;
  logic [TS_W-1:0]        first_ts;

  // Free-running timestamp that wraps naturally at 2^TS_W.
  always_ff @(posedge i_clk) begin
    if (i_rst) ts <= '0;
    else       ts <= ts + 1'b1;
  end

  // Previous-cycle interlock state used for edge detection. It resets to 0,
  // so bits already high when reset releases are logged.
  always_ff @(posedge i_clk) begin
    if (i_rst) prev <= '0;
    else       prev <= i_intl_state;
  end

  assign rise = i_intl_state & ~prev;

`ifdef INTL_EVT_FALL_LOG_EN
  logic [INTL_W-1:0] fall;
  assign fall     = ~i_intl_state & prev;
  assign evt_bits = rise | fall;
`else
  assign evt_bits = rise;
`endif

  assign evt  = |evt_bits;
  // A flush in the same cycle discards the event.
  assign push = evt & ~i_flush;
  // A drop happens only when the FIFO is full and no pop frees a slot.
  assign drop = push & fifo_full & ~i_rd_en;

  assign wr_entry = '{ts: ts, state: i_intl_state, bits: evt_bits};

  intl_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (push),
    .pop     (i_rd_en),
    .flush   (i_flush),
    .wr_data (wr_entry),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rd_entry = rd_word;

  // Sticky overflow flag. A same-cycle drop wins over the interlock reset.
  always_ff @(posedge i_clk) begin
    if (i_rst)           overflow <= 1'b0;
    else if (drop)       overflow <= 1'b1;
    else if (i_intl_rst) overflow <= 1'b0;
  end

  // First-fault latch. An interlock reset coinciding with a rise reloads the
  // latch with that rise, so no fault is lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      first_valid <= 1'b0;
      first_bits  <= '0;
      first_ts    <= '0;
    end else if (i_intl_rst) begin
      if (|rise) begin
        first_valid <= 1'b1;
        first_bits  <= rise;
        first_ts    <= ts;
      end else begin
        first_valid <= 1'b0;
        first_bits  <= '0;
        first_ts    <= '0;
      end
    end else if (!first_valid && (|rise)) begin
      first_valid <= 1'b1;
      first_bits  <= rise;
      first_ts    <= ts;
    end
  end

  // Head fields read as zero while empty, so stale storage never shows.
  assign o_evt_valid   = ~fifo_empty;
  assign o_evt_ts      = fifo_empty ? '0 : rd_entry.ts;
  assign o_evt_state   = fifo_empty ? '0 : rd_entry.state;
  assign o_evt_bits    = fifo_empty ? '0 : rd_entry.bits;
  assign o_evt_count   = fifo_count;
  assign o_overflow    = overflow;
  assign o_first_valid = first_valid;
  assign o_first_bits  = first_bits;
  assign o_first_ts    = first_ts;
  assign o_ts          = ts;

endmodule

// File: doc/intl_event_logger.md
# intl_event_logger

- Timestamped interlock event recorder placed directly downstream of the interlock block.
- Consumes the 16-bit interlock state vector and detects newly asserted interlock bits.
- Latches the first fault since the last interlock reset, with its timestamp.
- Queues every event in a show-ahead FIFO that the PS drains over the AXI register file.

## Interface
- DEPTH, 16, FIFO entries; power of two, 4..256
- TS_W, 32, timestamp counter width
- i_clk  in  1  system clock (AXI clock domain)
- i_rst  in  1  synchronous, active-high reset
- i_intl_state  in  16  interlock state vector from the interlock block
- i_intl_rst  in  1  one-cycle pulse; clears first-fault latch and overflow flag
- i_flush  in  1  one-cycle pulse; empties FIFO
- i_rd_en  in  1  one-cycle pop request for the FIFO head
- o_evt_valid  out  1  FIFO non-empty; head fields valid
- o_evt_ts  out  TS_W  head timestamp
- o_evt_state  out  16  head state snapshot
- o_evt_bits  out  16  head bits that caused the event
- o_evt_count  out  $clog2(DEPTH)+1  FIFO occupancy
- o_overflow  out  1  sticky; an event was dropped because the FIFO was full
- o_first_valid  out  1  first-fault latch loaded
- o_first_bits  out  16  bits that rose in the first-fault event
- o_first_ts  out  TS_W  timestamp of the first-fault event
- o_ts  out  TS_W  free-running timestamp counter

## Operation
- Timestamp: ts increments by 1 every cycle and wraps from 2^TS_W-1 to 0.
- Edge detect: `prev` holds i_intl_state registered each cycle.
  - `rise` = i_intl_state & ~prev.
  - An event occurs when `rise` ≠ 0.
  - Event bits are `rise`; the snapshot is i_intl_state; the timestamp is the current ts.
- FIFO push on event:
  - If not full, write {ts, state, bits}.
  - If full and no pop in the same cycle, drop the event and set o_overflow.
  - If full and i_rd_en in the same cycle, pop then push; no drop, count unchanged.
- Pop: i_rd_en with o_evt_valid=1 advances the head. i_rd_en when empty is ignored.
- Push while empty with pop in the same cycle: the pop is ignored (empty at the clock edge) and the push lands.
- Flush: i_flush clears the pointers and count; an event in the same cycle is discarded; o_overflow is unaffected.
- First fault: when o_first_valid=0 and an event occurs, load o_first_bits=`rise`, o_first_ts=ts, and set o_first_valid=1. Later events do not modify the latch.
- i_intl_rst: clears o_first_valid, o_first_bits, o_first_ts and o_overflow.
  - If an event occurs in the same cycle, the latch reloads with that event (no fault lost).
  - o_overflow ends 0 unless that same cycle also drops an event.
- Reset values (i_rst): every output 0, ts=0, FIFO empty.
  - `prev` resets to 0, so bits already high when reset releases produce an event on the first cycle after reset.

## Timing
- Event at input cycle N (ts=T):
  - o_evt_count, o_evt_valid and the head fields update at edge N+1.
  - o_first_* update at edge N+1.
  - The recorded timestamp is T.
- Pop at cycle M: the next head appears at edge M+1 (show-ahead; head outputs are registered or read from a registered address).
- Back-to-back events on consecutive cycles each produce one entry; sustained throughput is 1 event/cycle.
- No combinational path from inputs to outputs.

## Configuration
- INTL_EVT_FALL_LOG_EN defined:
  - Events also trigger on cleared bits: `fall` = ~i_intl_state & prev.
  - The entry stores `rise` | `fall` in o_evt_bits.
  - The first-fault latch still uses rising bits only.
- Undefined: only rising bits generate events; the fall logic is absent.

## Structure
- Package intl_evt_pkg contains:
  - INTL_W=16
  - the entry struct {ts, state, bits}
  - the ENTRY_W function of TS_W
- Sub-module intl_evt_fifo: synchronous show-ahead FIFO.
  - Parameters: DEPTH, WIDTH.
  - Ports: push, pop, flush, full, empty, count.
  - Pointers wrap using an extra MSB.
- The top level holds the timestamp counter, edge detect, first-fault latch and overflow flag.

## Test plan
- Reset, then i_intl_state 0x0000→0x0004 at ts=100 → one entry {ts=100, state=0x0004, bits=0x0004}; o_first_bits=0x0004, o_first_ts=100; count=1.
- Further change 0x0004→0x0014 at ts=105 → second entry with bits=0x0010; first-fault still 0x0004/100; then i_intl_rst → o_first_valid=0 and o_overflow=0, FIFO keeps 2 entries.
- 17 distinct rising events with DEPTH=16 and no pops → count=16, o_overflow=1, the 17th dropped; a pop plus event in the same cycle while full → count stays 16 and no new overflow.
- Pop all 16 entries → order matches push order with the correct timestamps; then an extra i_rd_en while empty → no change, o_evt_valid=0.
- i_intl_rst in the same cycle as a 0x0000→0x0100 rise at ts=500 → o_first_bits=0x0100, o_first_ts=500, o_first_valid=1.
- Force ts to 2^TS_W-2 (TS_W=8 build), event across the wrap → recorded timestamps 254, 255, 0; the INTL_EVT_FALL_LOG_EN build logs 0x0004→0x0000 with bits=0x0004.
